// File: rtl/vam_seq_mult.sv
// vam_seq_mult -- shift-and-add unsigned multiplier for the VAM-16 controller.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   begin a multiply (sampled only when idle)
//   inA    in   WIDTH     multiplicand
//   inB    in   WIDTH     multiplier
//   outW   out  2*WIDTH   registered product, held until the next completion
//   busy   out  high while iterating
//   done   out  one-cycle pulse when outW is updated
//
// Optional build macro: VAM_MULT_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero instead of always running WIDTH
// iterations. Products are identical; only latency changes.
module vam_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  output logic [2*WIDTH-1:0] outW,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;

  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // Accumulator value after the current iteration; also the final product
  // on the last iteration, so outW is loaded from it directly.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef VAM_MULT_EARLY_EXIT_EN
  // Once the shifted multiplier is empty, further iterations add nothing.
  assign w_last = (r_count == CW'(WIDTH-1)) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_count == CW'(WIDTH-1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      outW     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, inA};
            r_mplier <= inB;
            r_acc    <= '0;
            r_count  <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            outW    <= w_acc_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // start is ignored here; a held start is picked up from IDLE.
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vam_seq_mult.sv
// Bench for vam_seq_mult: an abstract cycle model (product = a*b, fixed
// latency) checked every cycle, plus directed vectors with literal results.
module tb_vam_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  inA = '0;
  logic [7:0]  inB = '0;
  logic [15:0] outW;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;

  vam_seq_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
    .outW(outW), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Iteration count the multiplier needs for operand b.
  function automatic int lat_of(input logic [7:0] b);
`ifdef VAM_MULT_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1..m_lat = busy, m_lat+1 = done cycle.
  int          m_ph;
  int          m_lat;
  logic [15:0] m_prod;
  logic [15:0] m_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph   <= 0;
      m_lat  <= 8;
      m_prod <= '0;
      m_out  <= '0;
    end else if (m_ph == 0) begin
      if (start) begin
        m_ph   <= 1;
        m_prod <= inA * inB;
        m_lat  <= lat_of(inB);
      end
    end else if (m_ph == m_lat) begin
      m_ph  <= m_lat + 1;
      m_out <= m_prod;
    end else if (m_ph == m_lat + 1) begin
      m_ph <= 0;
    end else begin
      m_ph <= m_ph + 1;
    end
  end

  always @(negedge clk) begin
    chk("model_busy", busy == (m_ph >= 1 && m_ph <= m_lat), 32'(busy), 32'(m_ph >= 1 && m_ph <= m_lat));
    chk("model_done", done == (m_ph == m_lat + 1), 32'(done), 32'(m_ph == m_lat + 1));
    chk("model_outW", outW == m_out, 32'(outW), 32'(m_out));
  end

  // Issue one multiply from IDLE and measure cycles from the start edge to done.
  task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                     input int lat_off, input int lat_on, input string nm);
    int  n;
    bit  seen;
    int  lat;
`ifdef VAM_MULT_EARLY_EXIT_EN
    lat = lat_on;
`else
    lat = lat_off;
`endif
    @(negedge clk);
    inA = a; inB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({nm, "_lat"}, seen && n == lat, 32'(n), 32'(lat));
    chk({nm, "_out"}, outW == exp, 32'(outW), 32'(exp));
  endtask

  // Wait for the next done pulse, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
  endtask

  initial begin
    int n1, n2;
    // reset state
    #2;
    chk("rst_outW", outW == 16'h0, 32'(outW), 32'h0);
    chk("rst_busy", busy == 1'b0, 32'(busy), 32'h0);
    chk("rst_done", done == 1'b0, 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", outW == 16'h0 && !busy && !done, 32'(outW), 32'h0);

    mul(8'hFF, 8'hFF, 16'hFE01, 8, 8, "ff_ff");
    mul(8'h00, 8'hA5, 16'h0000, 8, 8, "zero");
    mul(8'h80, 8'h02, 16'h0100, 8, 2, "x80_x02");
    mul(8'h05, 8'h00, 16'h0000, 8, 1, "b_zero");
    mul(8'h01, 8'h01, 16'h0001, 8, 1, "one");

    // outW holds through idle
    repeat (3) @(negedge clk);
    chk("hold_idle", outW == 16'h0001, 32'(outW), 32'h0001);

    // start and operand changes during RUN are ignored
    @(negedge clk);
    inA = 8'h12; inB = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    inA = 8'hFF; inB = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n1);
    chk("ign_out", done && outW == 16'h03A8, 32'(outW), 32'h03A8);
    wait_done(n2);
    chk("ign_single", n2 == 40, 32'(n2), 32'd40);

    // reset in the middle of RUN
    @(negedge clk);
    inA = 8'h33; inB = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outW", outW == 16'h0, 32'(outW), 32'h0);
    chk("midrst_busy", busy == 1'b0, 32'(busy), 32'h0);
    chk("midrst_done", done == 1'b0, 32'(done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_idle", !busy && !done && outW == 16'h0, 32'(outW), 32'h0);
    mul(8'h0F, 8'h0F, 16'h00E1, 8, 4, "x0f_x0f");

    // start held high: back-to-back multiplies
    @(negedge clk);
    inA = 8'h03; inB = 8'h05; start = 1'b1;
    @(negedge clk);
    inA = 8'h07; inB = 8'h09;
    wait_done(n1);
`ifdef VAM_MULT_EARLY_EXIT_EN
    chk("b2b_lat1", n1 == 3, 32'(n1), 32'd3);
`else
    chk("b2b_lat1", n1 == 8, 32'(n1), 32'd8);
`endif
    chk("b2b_out1", done && outW == 16'h000F, 32'(outW), 32'h000F);
    wait_done(n2);
    start = 1'b0;
`ifdef VAM_MULT_EARLY_EXIT_EN
    chk("b2b_gap", n2 == 6, 32'(n2), 32'd6);
`else
    chk("b2b_gap", n2 == 10, 32'(n2), 32'd10);
`endif
    chk("b2b_out2", done && outW == 16'h003F, 32'(outW), 32'h003F);
    repeat (4) @(negedge clk);

    // a few more model-checked vectors
    mul(8'hAA, 8'h55, 16'h3872, 8, 7, "aa_55");
    mul(8'h01, 8'h80, 16'h0080, 8, 8, "x01_x80");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
